mem2apb_bridge: RTL and testbench

MEM2APB_BRIDGE -- requirements
Module: mem2apb_bridge

---
 rtl/mem2apb_bridge.sv | 154 +++++++++++++++
 tb/tb_mem2apb_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem2apb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem2apb_bridge                                                  |
// | Purpose  : Single-outstanding CPU request port to APB master bridge.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem2apb_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  localparam int              c_CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int              c_LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [c_CW-1:0] c_LAST     = c_CW'(c_LAST_INT);
  localparam bit              c_TO_EN    = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERRRSP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_CW-1:0]       r_wait_cnt;

  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_timeout;
  logic                  w_active;
  logic                  w_rsp_valid;
  logic                  w_rsp_err;
  logic [DATA_WIDTH-1:0] w_rsp_rdata;

  // Ready is masked by the reset input so nothing is accepted while held in reset.
  assign req_ready    = (r_state == IDLE) && !PRESET;
  assign w_accept     = req_valid && req_ready;
  assign w_misaligned = (req_addr[1:0] != 2'b00);

  // Fires on the last permitted waiting cycle; PREADY is checked first in the FSM.
  assign w_timeout    = c_TO_EN && (r_wait_cnt == c_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_misaligned ? ERRRSP : SETUP;
        end
      end
      SETUP: begin
        w_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          w_next      = IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_write ? '0 : PRDATA;
        end else if (w_timeout) begin
          w_next      = IDLE;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
        end
      end
      ERRRSP: begin
        w_next      = IDLE;
        w_rsp_valid = 1'b1;
        w_rsp_err   = 1'b1;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wait_cnt  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      // Held at zero outside ACCESS, so it is already clear on entry.
      if (r_state != ACCESS) begin
        r_wait_cnt <= '0;
      end else if (!PREADY && c_TO_EN) begin
        r_wait_cnt <= r_wait_cnt + c_CW'(1);
      end
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  assign w_active  = (r_state == SETUP) || (r_state == ACCESS);
  assign PSEL      = w_active;
  assign PENABLE   = (r_state == ACCESS);
  assign PWRITE    = w_active && r_write;
  assign PADDR     = w_active ? r_addr  : '0;
  assign PWDATA    = w_active ? r_wdata : '0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem2apb_bridge.sv
`default_nettype none
// Randomized bench for mem2apb_bridge: transaction-level model of latency,
// error and data behaviour plus a simple memory-backed APB slave.
module tb_mem2apb_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          PRESET;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic [DW-1:0] PRDATA;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
  } txn_t;

  txn_t        txq[$];
  logic [31:0] mem [bit [31:0]];

  mem2apb_bridge #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK     (clk),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom();
    return mem[a];
  endfunction

  task automatic present(input txn_t t);
    req_valid = 1'b1;
    req_write = t.wr;
    req_addr  = t.addr;
    req_wdata = t.wdata;
  endtask

  task automatic junk_req();
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = $urandom();
    req_wdata = $urandom();
  endtask

  // Runs every queued transaction; b2b keeps req_valid high with the next request.
  task automatic run_queue(input bit b2b);
    txn_t        t;
    bit          aligned, err, e_psel, e_pen, e_rv;
    int          n_acc, rsp_k;
    logic [31:0] rd_val, exp_rd, e_paddr, e_pwdata, e_rdata;
    if (txq.size() == 0) return;
    @(negedge clk);
    present(txq[0]);
    while (txq.size() > 0) begin
      t       = txq.pop_front();
      aligned = (t.addr[1:0] == 2'b00);
      err     = !aligned || (t.waits >= TO);
      n_acc   = aligned ? ((t.waits + 1 < TO) ? t.waits + 1 : TO) : 0;
      rsp_k   = 2 + n_acc;
      rd_val  = 32'h0;
      if (aligned && !t.wr && !err) rd_val = slave_read(t.addr);
      exp_rd  = (err || t.wr) ? 32'h0 : rd_val;
      if (t.wr && !err) mem[t.addr] = t.wdata;
      @(posedge clk);
      for (int k = 1; k <= rsp_k; k++) begin
        @(negedge clk);
        e_psel   = aligned && (k <= 1 + n_acc);
        e_pen    = aligned && (k >= 2) && (k <= 1 + n_acc);
        e_rv     = (k == rsp_k);
        e_paddr  = e_psel ? t.addr  : 32'h0;
        e_pwdata = e_psel ? t.wdata : 32'h0;
        e_rdata  = e_rv ? exp_rd : 32'h0;
        total++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== {e_psel, e_pen, e_rv, e_rv}) begin
          bad++;
          $display("FAIL ctrl addr=%h cyc=%0d got psel/pen/rv/rdy=%b%b%b%b want %b%b%b%b",
                   t.addr, k, PSEL, PENABLE, rsp_valid, req_ready, e_psel, e_pen, e_rv, e_rv);
        end
        total++;
        if (PADDR !== e_paddr || PWDATA !== e_pwdata || (e_psel && PWRITE !== t.wr)) begin
          bad++;
          $display("FAIL apb_bus cyc=%0d got paddr=%h pwdata=%h pwrite=%b want %h %h %b",
                   k, PADDR, PWDATA, PWRITE, e_paddr, e_pwdata, t.wr);
        end
        total++;
        if (rsp_err !== (e_rv && err) || rsp_rdata !== e_rdata) begin
          bad++;
          $display("FAIL rsp addr=%h cyc=%0d got err=%b rdata=%h want err=%b rdata=%h",
                   t.addr, k, rsp_err, rsp_rdata, e_rv && err, e_rdata);
        end
        if (b2b && txq.size() > 0) present(txq[0]);
        else junk_req();
        if (e_pen) begin
          PREADY = ((k - 2) == t.waits);
          PRDATA = PREADY ? rd_val : $urandom();
        end else begin
          PREADY = 1'($urandom_range(0, 1));
          PRDATA = $urandom();
        end
      end
      if (!b2b && txq.size() > 0) begin
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({PSEL, PENABLE, rsp_valid, req_ready} !== 4'b0001) begin
          bad++;
          $display("FAIL idle_gap got psel/pen/rv/rdy=%b%b%b%b want 0001",
                   PSEL, PENABLE, rsp_valid, req_ready);
        end
        present(txq[0]);
      end
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    PREADY = 1'b1;
    PRDATA = $urandom();
    present('{wr: 1'b1, addr: 32'h40, wdata: 32'h1234_5678, waits: 0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE} !== 6'b0 ||
          PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
        bad++;
        $display("FAIL reset_hold got rdy/rv/err/psel/pen/pw=%b%b%b%b%b%b paddr=%h pwdata=%h rdata=%h want all 0",
                 req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata);
      end
    end
    PRESET = 1'b0;
    junk_req();
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, PSEL, PENABLE} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_release got rdy/rv/psel/pen=%b%b%b%b want 1000",
               req_ready, rsp_valid, PSEL, PENABLE);
    end
  endtask

  task automatic test_write_fixed();
    txq.push_back('{wr: 1'b1, addr: 32'h10, wdata: 32'hA5A5_0001, waits: 0});
    run_queue(1'b0);
  endtask

  task automatic test_read_wait();
    mem[32'h4] = 32'h0000_00FF;
    txq.push_back('{wr: 1'b0, addr: 32'h4, wdata: 32'h0, waits: 3});
    run_queue(1'b0);
  endtask

  task automatic test_misaligned();
    txq.push_back('{wr: 1'b0, addr: 32'h6, wdata: 32'h0, waits: 0});
    txq.push_back('{wr: 1'b1, addr: 32'h13, wdata: 32'hDEAD_BEEF, waits: 0});
    run_queue(1'b0);
  endtask

  task automatic test_timeout();
    txq.push_back('{wr: 1'b0, addr: 32'h8, wdata: 32'h0, waits: 50});
    txq.push_back('{wr: 1'b0, addr: 32'h8, wdata: 32'h0, waits: TO - 1});
    txq.push_back('{wr: 1'b1, addr: 32'hC, wdata: 32'h0BAD_F00D, waits: TO});
    run_queue(1'b0);
  endtask

  task automatic test_back_to_back();
    txq.push_back('{wr: 1'b1, addr: 32'h20, wdata: 32'h1111_2222, waits: 0});
    txq.push_back('{wr: 1'b1, addr: 32'h24, wdata: 32'h3333_4444, waits: 0});
    txq.push_back('{wr: 1'b0, addr: 32'h20, wdata: 32'h0, waits: 1});
    txq.push_back('{wr: 1'b0, addr: 32'h24, wdata: 32'h0, waits: 0});
    run_queue(1'b1);
  endtask

  task automatic test_random();
    txn_t t;
    int   r;
    for (int b = 0; b < 8; b++) begin
      for (int n = 0; n < int'($urandom_range(3, 6)); n++) begin
        t.wr    = 1'($urandom_range(0, 1));
        t.addr  = 32'($urandom_range(0, 15)) << 2;
        if ($urandom_range(0, 5) == 0) t.addr[1:0] = 2'($urandom_range(1, 3));
        t.wdata = $urandom();
        r       = int'($urandom_range(0, 9));
        t.waits = (r < 7) ? (r % 4) : ((r == 7) ? TO - 1 : TO + int'($urandom_range(0, 3)));
        txq.push_back(t);
      end
      run_queue(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    present('{wr: 1'b0, addr: 32'h28, wdata: 32'h0, waits: 0});
    PREADY = 1'b0;
    @(posedge clk);
    @(negedge clk);
    junk_req();
    PREADY = 1'b0;
    @(negedge clk);
    total++;
    if (PENABLE !== 1'b1) begin
      bad++;
      $display("FAIL mid_access got penable=%b want 1", PENABLE);
    end
    PRESET = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE} !== 6'b0 ||
        PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset got rdy/rv/err/psel/pen/pw=%b%b%b%b%b%b paddr=%h want all 0",
               req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE, PADDR);
    end
    PRESET = 1'b0;
    PREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || PSEL !== 1'b0) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got rv=%b rdy=%b psel=%b want 0 1 0",
                 i, rsp_valid, req_ready, PSEL);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_fixed();
    test_read_wait();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_write_fixed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
